// File: rtl/slot_alloc_pkg.sv
// Shared constants and types for the slot allocator.
package slot_alloc_pkg;

  localparam int DEFAULT_SIZE = 8;

  function automatic int idx_width(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_SIZE);

  typedef logic [DEFAULT_IDX_W-1:0] slot_idx_t;
  typedef logic [DEFAULT_IDX_W:0]   slot_cnt_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/free_slot_finder.sv
// Combinational search for the highest (A) and next-highest (B) free slot.
module free_slot_finder
  import slot_alloc_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int IDX_W = idx_width(SIZE)
) (
  input  logic [SIZE-1:0]  free_vec_i,
  output logic [IDX_W-1:0] a_idx_o,
  output logic             a_vld_o,
  output logic [IDX_W-1:0] b_idx_o,
  output logic             b_vld_o
);

  logic [IDX_W-1:0] a_idx, b_idx;
  logic             a_vld, b_vld;

  // Ascending scan: each new free slot demotes the previous best to B.
  always_comb begin
    a_idx = '0;
    a_vld = 1'b0;
    b_idx = '0;
    b_vld = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (free_vec_i[i]) begin
        b_idx = a_idx;
        b_vld = a_vld;
        a_idx = IDX_W'(i);
        a_vld = 1'b1;
      end
    end
  end

  assign a_idx_o = a_idx;
  assign a_vld_o = a_vld;
  assign b_idx_o = b_idx;
  assign b_vld_o = b_vld;

endmodule

// File: rtl/slot_alloc_ctrl.sv
// Two-port slot allocator over a busy bitmap with release, flush and error flag.
// Define SLOT_ALLOC_STATS_EN to add the saturating stall_cnt output.
module slot_alloc_ctrl
  import slot_alloc_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int IDX_W = idx_width(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alloc_req,
  output logic [1:0]       alloc_gnt,
  output logic [IDX_W-1:0] alloc_idx0,
  output logic [IDX_W-1:0] alloc_idx1,
  input  logic [1:0]       free_vld,
  input  logic [IDX_W-1:0] free_idx0,
  input  logic [IDX_W-1:0] free_idx1,
  input  logic             flush,
  output logic [IDX_W:0]   free_cnt,
  output logic             full,
  output logic             empty,
  output logic             err_dbl_free
`ifdef SLOT_ALLOC_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int CNT_W = IDX_W + 1;

  logic [SIZE-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] a_idx, b_idx;
  logic             a_vld, b_vld;

  logic [SIZE-1:0]  gnt_mask, rel_mask;
  logic             rel0, rel1, dbl_free;
  logic [1:0]       n_rel, n_gnt;

  free_slot_finder #(
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) u_finder (
    .free_vec_i (~busy_q),
    .a_idx_o    (a_idx),
    .a_vld_o    (a_vld),
    .b_idx_o    (b_idx),
    .b_vld_o    (b_vld)
  );

  assign full  = (free_cnt_q == '0);
  assign empty = (free_cnt_q == CNT_W'(SIZE));

  // Port 1 takes B only alongside a port-0 request, otherwise A.
  always_comb begin
    alloc_gnt  = 2'b00;
    alloc_idx0 = a_idx;
    alloc_idx1 = alloc_req[0] ? b_idx : a_idx;
    if (rst_n && !flush && !full) begin
      alloc_gnt[0] = alloc_req[0] & a_vld;
      alloc_gnt[1] = alloc_req[1] & (alloc_req[0] ? b_vld : a_vld);
    end
  end

  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_mask
      assign gnt_mask[gi] = (alloc_gnt[0] && alloc_idx0 == IDX_W'(gi)) ||
                            (alloc_gnt[1] && alloc_idx1 == IDX_W'(gi));
      assign rel_mask[gi] = busy_q[gi] &&
                            ((free_vld[0] && free_idx0 == IDX_W'(gi)) ||
                             (free_vld[1] && free_idx1 == IDX_W'(gi)));
    end
  endgenerate

  // A duplicate release of the same busy slot on both ports counts once.
  assign rel0     = free_vld[0] & busy_q[free_idx0];
  assign rel1     = free_vld[1] & busy_q[free_idx1] & ~(rel0 && free_idx1 == free_idx0);
  assign dbl_free = (free_vld[0] & ~busy_q[free_idx0]) | (free_vld[1] & ~busy_q[free_idx1]);
  assign n_rel    = {1'b0, rel0} + {1'b0, rel1};
  assign n_gnt    = {1'b0, alloc_gnt[0]} + {1'b0, alloc_gnt[1]};

  always_comb begin
    busy_d     = (busy_q & ~rel_mask) | gnt_mask;
    free_cnt_d = free_cnt_q + CNT_W'(n_rel) - CNT_W'(n_gnt);
    err_d      = err_q | dbl_free;
    if (flush) begin
      busy_d     = '0;
      free_cnt_d = CNT_W'(SIZE);
      err_d      = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      free_cnt_q <= CNT_W'(SIZE);
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
    end
  end

  assign free_cnt     = free_cnt_q;
  assign err_dbl_free = err_q;

`ifdef SLOT_ALLOC_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (|(alloc_req & ~alloc_gnt) && stall_q != STALL_MAX) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_slot_alloc_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic vs. a free-list model.
module tb_slot_alloc_ctrl;
  import slot_alloc_pkg::*;

  localparam int SIZE = DEFAULT_SIZE;

  logic       clk;
  logic       rst_n;
  logic [1:0] alloc_req;
  logic [1:0] alloc_gnt;
  slot_idx_t  alloc_idx0, alloc_idx1;
  logic [1:0] free_vld;
  slot_idx_t  free_idx0, free_idx1;
  logic       flush;
  slot_cnt_t  free_cnt;
  logic       full, empty, err_dbl_free;
`ifdef SLOT_ALLOC_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_busy[SIZE];
  bit         m_err;
  int         m_stall;
  logic [1:0] e_gnt;
  slot_idx_t  e_idx0, e_idx1;

  slot_alloc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_idx0   (alloc_idx0),
    .alloc_idx1   (alloc_idx1),
    .free_vld     (free_vld),
    .free_idx0    (free_idx0),
    .free_idx1    (free_idx1),
    .flush        (flush),
    .free_cnt     (free_cnt),
    .full         (full),
    .empty        (empty),
    .err_dbl_free (err_dbl_free)
`ifdef SLOT_ALLOC_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_free_cnt();
    int n = 0;
    for (int i = 0; i < SIZE; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_comb();
    int fl[$];
    int need;
    for (int i = SIZE - 1; i >= 0; i--) if (!m_busy[i]) fl.push_back(i);
    e_gnt  = 2'b00;
    e_idx0 = '0;
    e_idx1 = '0;
    if (rst_n && !flush) begin
      if (alloc_req[0] && fl.size() >= 1) begin
        e_gnt[0] = 1'b1;
        e_idx0   = slot_idx_t'(fl[0]);
      end
      need = alloc_req[0] ? 2 : 1;
      if (alloc_req[1] && fl.size() >= need) begin
        e_gnt[1] = 1'b1;
        e_idx1   = slot_idx_t'(fl[need-1]);
      end
    end
  endtask

  task automatic model_update();
    bit old_busy[SIZE];
    if (!rst_n || flush) begin
      for (int i = 0; i < SIZE; i++) m_busy[i] = 1'b0;
      if (!rst_n) m_err = 1'b0;
      m_stall = 0;
    end else begin
      old_busy = m_busy;
      if (free_vld[0]) begin
        if (old_busy[free_idx0]) m_busy[free_idx0] = 1'b0; else m_err = 1'b1;
      end
      if (free_vld[1]) begin
        if (old_busy[free_idx1]) m_busy[free_idx1] = 1'b0; else m_err = 1'b1;
      end
      if (e_gnt[0]) m_busy[e_idx0] = 1'b1;
      if (e_gnt[1]) m_busy[e_idx1] = 1'b1;
      if ((alloc_req & ~e_gnt) != 2'b00 && m_stall < 65535) m_stall++;
    end
  endtask

  task automatic tick();
    model_comb();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] req, input logic [1:0] fv,
                        input int fi0, input int fi1, input logic fl);
    alloc_req = req;
    free_vld  = fv;
    free_idx0 = slot_idx_t'(fi0);
    free_idx1 = slot_idx_t'(fi1);
    flush     = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(2'b11, 2'b00, 0, 0, 1'b0);
    #1;
    total++;
    if (alloc_gnt !== 2'b00) begin
      bad++; $display("FAIL reset_gnt got=%b want=00", alloc_gnt);
    end
    tick();
    rst_n = 1'b1;
    set_in(2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt !== slot_cnt_t'(SIZE) || empty !== 1'b1 || full !== 1'b0 || err_dbl_free !== 1'b0) begin
      bad++; $display("FAIL reset_state got cnt=%0d empty=%b full=%b err=%b want cnt=%0d 1 0 0",
                      free_cnt, empty, full, err_dbl_free, SIZE);
    end
    $display("test_reset: cnt=%0d empty=%b", free_cnt, empty);
  endtask

  task automatic test_fill();
    set_in(2'b11, 2'b00, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (alloc_gnt !== 2'b11 || alloc_idx0 !== slot_idx_t'(7 - 2*k) || alloc_idx1 !== slot_idx_t'(6 - 2*k)) begin
        bad++; $display("FAIL fill_pair%0d got gnt=%b idx=%0d,%0d want 11 idx=%0d,%0d",
                        k, alloc_gnt, alloc_idx0, alloc_idx1, 7 - 2*k, 6 - 2*k);
      end
      if (k == 1) begin
        total++;
        if (free_cnt !== slot_cnt_t'(6)) begin
          bad++; $display("FAIL fill_cnt got=%0d want=6", free_cnt);
        end
      end
      $display("test_fill: cycle %0d gnt=%b idx=%0d,%0d", k, alloc_gnt, alloc_idx0, alloc_idx1);
      tick();
    end
    #1;
    total++;
    if (full !== 1'b1 || alloc_gnt !== 2'b00) begin
      bad++; $display("FAIL full_deny got full=%b gnt=%b want 1 00", full, alloc_gnt);
    end
    tick();
  endtask

  task automatic test_free_alloc();
    set_in(2'b01, 2'b01, 3, 0, 1'b0);
    #1;
    total++;
    if (alloc_gnt !== 2'b00) begin
      bad++; $display("FAIL free_same_cycle got gnt=%b want 00", alloc_gnt);
    end
    tick();
    set_in(2'b01, 2'b00, 0, 0, 1'b0);
    #1;
    total++;
    if (alloc_gnt !== 2'b01 || alloc_idx0 !== slot_idx_t'(3)) begin
      bad++; $display("FAIL free_next_cycle got gnt=%b idx0=%0d want 01 idx0=3", alloc_gnt, alloc_idx0);
    end
    $display("test_free_alloc: gnt=%b idx0=%0d", alloc_gnt, alloc_idx0);
    tick();
  endtask

  task automatic test_dbl_free();
    set_in(2'b00, 2'b11, 5, 5, 1'b0);
    tick();
    set_in(2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt !== slot_cnt_t'(1) || err_dbl_free !== 1'b0) begin
      bad++; $display("FAIL same_idx_free got cnt=%0d err=%b want 1 0", free_cnt, err_dbl_free);
    end
    set_in(2'b00, 2'b01, 5, 0, 1'b0);
    tick();
    set_in(2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    total++;
    if (err_dbl_free !== 1'b1 || free_cnt !== slot_cnt_t'(1)) begin
      bad++; $display("FAIL dbl_free got err=%b cnt=%0d want 1 1", err_dbl_free, free_cnt);
    end
    $display("test_dbl_free: cnt=%0d err=%b", free_cnt, err_dbl_free);
  endtask

  task automatic test_flush();
    set_in(2'b01, 2'b00, 0, 0, 1'b0);
    tick();
    set_in(2'b11, 2'b00, 0, 0, 1'b1);
    #1;
    total++;
    if (full !== 1'b1 || alloc_gnt !== 2'b00) begin
      bad++; $display("FAIL flush_gnt got full=%b gnt=%b want 1 00", full, alloc_gnt);
    end
    tick();
    set_in(2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt !== slot_cnt_t'(SIZE) || empty !== 1'b1) begin
      bad++; $display("FAIL flush_state got cnt=%0d empty=%b want %0d 1", free_cnt, empty, SIZE);
    end
    $display("test_flush: cnt=%0d empty=%b", free_cnt, empty);
  endtask

`ifdef SLOT_ALLOC_STATS_EN
  task automatic test_stall();
    set_in(2'b11, 2'b00, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    set_in(2'b01, 2'b00, 0, 0, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    set_in(2'b00, 2'b00, 0, 0, 1'b0);
    #1;
    total++;
    if (stall_cnt !== 16'd10) begin
      bad++; $display("FAIL stall_cnt got=%0d want=10", stall_cnt);
    end
    $display("test_stall: stall_cnt=%0d", stall_cnt);
  endtask
`endif

  task automatic test_random();
    int exp_cnt;
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      alloc_req = 2'($urandom_range(0, 3));
      free_vld  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      free_idx0 = slot_idx_t'($urandom_range(0, SIZE - 1));
      free_idx1 = ($urandom_range(0, 3) == 0) ? free_idx0 : slot_idx_t'($urandom_range(0, SIZE - 1));
      #1;
      model_comb();
      exp_cnt = model_free_cnt();
      total++;
      if (alloc_gnt !== e_gnt) begin
        bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, alloc_gnt, e_gnt);
      end
      if (e_gnt[0]) begin
        total++;
        if (alloc_idx0 !== e_idx0) begin
          bad++; $display("FAIL rnd_idx0 c=%0d got=%0d want=%0d", c, alloc_idx0, e_idx0);
        end
      end
      if (e_gnt[1]) begin
        total++;
        if (alloc_idx1 !== e_idx1) begin
          bad++; $display("FAIL rnd_idx1 c=%0d got=%0d want=%0d", c, alloc_idx1, e_idx1);
        end
      end
      total++;
      if (free_cnt !== slot_cnt_t'(exp_cnt) || full !== (exp_cnt == 0) ||
          empty !== (exp_cnt == SIZE) || err_dbl_free !== m_err) begin
        bad++; $display("FAIL rnd_state c=%0d got cnt=%0d full=%b empty=%b err=%b want cnt=%0d err=%b",
                        c, free_cnt, full, empty, err_dbl_free, exp_cnt, m_err);
      end
`ifdef SLOT_ALLOC_STATS_EN
      total++;
      if (stall_cnt !== 16'(m_stall)) begin
        bad++; $display("FAIL rnd_stall c=%0d got=%0d want=%0d", c, stall_cnt, m_stall);
      end
`endif
      $display("rnd c=%0d rst_n=%b fl=%b req=%b fv=%b gnt=%b cnt=%0d",
               c, rst_n, flush, alloc_req, free_vld, alloc_gnt, free_cnt);
      tick();
    end
  endtask

  initial begin
    m_err   = 1'b0;
    m_stall = 0;
    for (int i = 0; i < SIZE; i++) m_busy[i] = 1'b0;
    test_reset();
    test_fill();
    test_free_alloc();
    test_dbl_free();
    test_flush();
`ifdef SLOT_ALLOC_STATS_EN
    test_stall();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slot_alloc_ctrl.md
SLOT_ALLOC_CTRL -- requirements
Module: slot_alloc_ctrl

Interface
REQ-001 Parameter SIZE, default 8, number of managed slots (power of two, 4..32).
REQ-002 Parameter IDX_W, default $clog2(SIZE), slot index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 alloc_req  input  2  per-port allocation request; port 0 has priority.
REQ-006 alloc_gnt  output  2  per-port grant, same cycle as request (combinational from registered state).
REQ-007 alloc_idx0, alloc_idx1  output  IDX_W each  granted slot index per port; meaningful only when the matching grant is 1.
REQ-008 free_vld  input  2  per-port release strobe.
REQ-009 free_idx0, free_idx1  input  IDX_W each  slot index released per port.
REQ-010 flush  input  1  release all slots.
REQ-011 free_cnt  output  IDX_W+1  registered count of free slots.
REQ-012 full, empty  output  1 each  full = no free slot; empty = all slots free.
REQ-013 err_dbl_free  output  1  sticky flag: release of a slot that was not busy.

Function
REQ-014 State: busy bitmap of SIZE bits, plus a registered free_cnt.
REQ-015 Candidate A is the highest-index free slot; candidate B is the next-highest free slot below A.
REQ-016 Grants:
- Port 0 is granted A if alloc_req[0] and at least one slot is free.
- Port 1 is granted B when port 0 is also granted.
- Port 1 is granted A when alloc_req[0]=0.
- Port 1 gets no grant when fewer free slots exist than needed.
REQ-017 Grants are all-or-nothing per port, with no partial index; an ungranted request holds no state and the requester retries.
REQ-018 Granted slots become busy at the next edge; they are reflected in free_cnt and full one cycle later.
REQ-019 Released slots become free at the next edge; a slot freed in cycle N is not grantable before cycle N+1.
REQ-020 Both free ports naming the same busy index clear it once and decrement busy count by one; err_dbl_free is not set.
REQ-021 Release of a non-busy index is ignored and sets err_dbl_free at the next edge.
REQ-022 free_cnt(next) = free_cnt + distinct valid releases - grants, never outside 0..SIZE.
REQ-023 flush has priority over same-cycle allocs and frees: next state is all slots free and free_cnt=SIZE; alloc_gnt is forced to 0 during flush.
REQ-024 When full=1, alloc_gnt=0 regardless of alloc_req.

Reset
REQ-025 When rst_n=0 at an edge, the next state is:
- busy=0, free_cnt=SIZE, empty=1, full=0, err_dbl_free=0.
- alloc_gnt=0 while rst_n=0.
REQ-026 Reset mid-operation discards all outstanding allocations without error.

Configuration
REQ-027 Macro SLOT_ALLOC_STATS_EN defined adds the following:
- Output stall_cnt, 16 bits, a saturating count of cycles with any alloc_req bit set and its grant denied.
- stall_cnt is cleared by reset and flush.
REQ-028 Without SLOT_ALLOC_STATS_EN, neither the port nor the counter exists; all other behaviour is identical.

Structure
REQ-029 Package slot_alloc_pkg holds the following:
- Default SIZE constant.
- IDX_W derivation.
- slot_idx_t typedef.
- Count typedef (IDX_W+1 bits).
REQ-030 Sub-module free_slot_finder is purely combinational. It takes the inverted busy vector and returns A, B, and valid bits for each.

Verification
REQ-031 Reset, SIZE=8, alloc_req=11 -> gnt=11, idx0=7, idx1=6; next cycle free_cnt=6.
REQ-032 Repeat allocation on both ports for 4 cycles -> 4th grant pair is idx 1,0; then full=1 and alloc_req=11 gives gnt=00.
REQ-033 Full, then free_vld=01 with free_idx0=3 plus alloc_req=01 in the same cycle -> gnt=0 that cycle; next cycle gnt=01 with idx0=3.
REQ-034 free_vld=11 with both indices=5 while slot 5 busy -> free_cnt +1, err_dbl_free stays 0; a later free of 5 -> err_dbl_free=1.
REQ-035 Full, then flush=1 with alloc_req=11 -> gnt=00; next cycle free_cnt=8, empty=1.
REQ-036 With SLOT_ALLOC_STATS_EN, hold alloc_req=01 while full for 10 cycles -> stall_cnt=10.
